// File: rtl/fifo_write_arbiter_if.sv
// Write-side bundle between NUM_REQ producers, the arbiter and the shared FIFO write port.
// master: producers/FIFO environment; slave: the arbiter.
interface fifo_write_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            ack;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_din;
    logic                          gnt_valid;
    logic [ID_W-1:0]               gnt_id;

    modport master (
        output req, req_data, fifo_full,
        input  ack, fifo_wr_en, fifo_din, gnt_valid, gnt_id
    );

    modport slave (
        input  req, req_data, fifo_full,
        output ack, fifo_wr_en, fifo_din, gnt_valid, gnt_id
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-limited write arbiter in front of a shared FIFO.
// FIFO_WRITE_ARB_PRIO_EN: producer 0 becomes high priority and is not burst-limited.
module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int BURST_LEN  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_write_arbiter_if.slave  bus
);
    localparam int unsigned NREQ      = NUM_REQ;
    localparam logic [3:0]  LAST_BEAT = 4'(BURST_LEN - 1);

    typedef enum logic {ARB, GRANT} state_t;
    state_t state, state_nxt;

    logic [ID_W-1:0] gnt_id_q;
    logic [ID_W-1:0] last_gnt_q;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] cand;
    logic            found;
    logic            gnt_valid_q;
    logic [3:0]      burst_cnt_q;
    logic            cur_req;
    logic            xfer;
    logic            burst_limited;
    logic            burst_done;
    logic            grant_end;

    assign cur_req = bus.req[gnt_id_q];
    assign xfer    = (state == GRANT) && cur_req && !bus.fifo_full;

`ifdef FIFO_WRITE_ARB_PRIO_EN
    assign burst_limited = (gnt_id_q != '0);
`else
    assign burst_limited = 1'b1;
`endif

    assign burst_done = xfer && burst_limited && (burst_cnt_q == LAST_BEAT);
    assign grant_end  = (state == GRANT) && (!cur_req || burst_done);

    // First requester scanning upward from last_gnt+1, wrapping at NUM_REQ.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = ID_W'((32'(last_gnt_q) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
`ifdef FIFO_WRITE_ARB_PRIO_EN
        if (bus.req[0]) begin
            winner = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB:   if (|bus.req) state_nxt = GRANT;
            GRANT: if (grant_end) state_nxt = ARB;
        endcase
    end

    // The counter saturates so an unlimited grant never runs past BURST_LEN-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            last_gnt_q  <= ID_W'(NUM_REQ - 1);
            burst_cnt_q <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (|bus.req) begin
                        gnt_id_q    <= winner;
                        gnt_valid_q <= 1'b1;
                        burst_cnt_q <= '0;
                    end
                end
                GRANT: begin
                    if (grant_end) begin
                        gnt_valid_q <= 1'b0;
                        last_gnt_q  <= gnt_id_q;
                    end else if (xfer && (burst_cnt_q != LAST_BEAT)) begin
                        burst_cnt_q <= burst_cnt_q + 4'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.ack        = '0;
        bus.fifo_wr_en = 1'b0;
        bus.fifo_din   = '0;
        bus.gnt_valid  = gnt_valid_q;
        bus.gnt_id     = gnt_id_q;
        if (state == GRANT) begin
            bus.fifo_wr_en    = xfer;
            bus.ack[gnt_id_q] = xfer;
            bus.fifo_din      = bus.req_data[32'(gnt_id_q)*DATA_WIDTH +: DATA_WIDTH];
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: vector table, directed corner sequences,
// and randomized producers checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_fifo_write_arbiter;
    localparam int DW = 8;
    localparam int NR = 4;
    localparam int IW = 2;
    localparam int BL = 4;
`ifdef FIFO_WRITE_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_write_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_W(IW)) bus ();

    fifo_write_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_REQ(NR),
        .ID_W(IW),
        .BURST_LEN(BL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] req;
        logic          full;
        logic          exp_valid;
        logic [IW-1:0] exp_id;
        logic          exp_wr;
        logic [NR-1:0] exp_ack;
        logic [DW-1:0] exp_din;
    } vec_t;

    vec_t tbl [11];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: which producer owns the port (-1 = none), words it has moved,
    // and who owned it last.
    int m_active;
    int m_last;
    int m_words;
    logic [NR-1:0] seen_ack;
    int wr_log [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = -1;
        m_last   = NR - 1;
        m_words  = 0;
    endtask

    function automatic int m_pick(input logic [NR-1:0] r);
        if (PRIO && r[0]) return 0;
        for (int k = 1; k <= NR; k++) begin
            int c = (m_last + k) % NR;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_check();
        logic          x;
        logic [DW-1:0] d;
        if (m_active < 0) begin
            check("gnt_valid", 32'(bus.gnt_valid), 0);
            check("fifo_wr_en", 32'(bus.fifo_wr_en), 0);
            check("ack", 32'(bus.ack), 0);
            check("fifo_din", 32'(bus.fifo_din), 0);
        end else begin
            x = bus.req[m_active] && !bus.fifo_full;
            d = bus.req_data[m_active*DW +: DW];
            check("gnt_valid", 32'(bus.gnt_valid), 1);
            check("gnt_id", 32'(bus.gnt_id), 32'(m_active));
            check("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(x));
            check("ack", 32'(bus.ack), x ? (32'd1 << m_active) : 32'd0);
            check("fifo_din", 32'(bus.fifo_din), 32'(d));
        end
    endtask

    task automatic model_advance();
        if (m_active < 0) begin
            if (bus.req != '0) begin
                m_active = m_pick(bus.req);
                m_words  = 0;
            end
        end else if (!bus.req[m_active]) begin
            m_last   = m_active;
            m_active = -1;
        end else if (!bus.fifo_full) begin
            m_words++;
            if (m_words == BL && !(PRIO && m_active == 0)) begin
                m_last   = m_active;
                m_active = -1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        seen_ack = bus.ack;
        if (bus.fifo_wr_en) wr_log.push_back(int'(bus.gnt_id));
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req       = '0;
        bus.fifo_full = 1'b0;
        seen_ack      = '0;
        model_reset();
        @(negedge clk);
        check("rst_gnt_valid", 32'(bus.gnt_valid), 0);
        check("rst_gnt_id", 32'(bus.gnt_id), 0);
        check("rst_wr_en", 32'(bus.fifo_wr_en), 0);
        check("rst_ack", 32'(bus.ack), 0);
        check("rst_din", 32'(bus.fifo_din), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_log.delete();
    endtask

    function automatic int count_id(input int id);
        int n = 0;
        foreach (wr_log[i]) if (wr_log[i] == id) n++;
        return n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req       = '0;
        bus.req_data  = {8'h44, 8'h33, 8'h22, 8'hA5};
        bus.fifo_full = 1'b0;
        model_reset();

        // Producer 0 alone, data A5: arbitration latency, one burst, bubble, stall, drop.
        tbl[0] = '{4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00};
        tbl[1] = '{4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 8'hA5};
        tbl[2] = '{4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 8'hA5};
        tbl[3] = '{4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 8'hA5};
        tbl[4] = '{4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 8'hA5};
`ifdef FIFO_WRITE_ARB_PRIO_EN
        tbl[5] = '{4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 8'hA5};
`else
        tbl[5] = '{4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00};
`endif
        tbl[6]  = '{4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 8'hA5};
        tbl[7]  = '{4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0000, 8'hA5};
        tbl[8]  = '{4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 8'hA5};
        tbl[9]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000, 8'hA5};
        tbl[10] = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            bus.req       = tbl[i].req;
            bus.fifo_full = tbl[i].full;
            @(negedge clk);
            check($sformatf("tbl%0d_valid", i), 32'(bus.gnt_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid)
                check($sformatf("tbl%0d_id", i), 32'(bus.gnt_id), 32'(tbl[i].exp_id));
            check($sformatf("tbl%0d_wr", i), 32'(bus.fifo_wr_en), 32'(tbl[i].exp_wr));
            check($sformatf("tbl%0d_ack", i), 32'(bus.ack), 32'(tbl[i].exp_ack));
            check($sformatf("tbl%0d_din", i), 32'(bus.fifo_din), 32'(tbl[i].exp_din));
            @(posedge clk);
            #1;
        end

`ifndef FIFO_WRITE_ARB_PRIO_EN
        // Everyone requesting: 0,1,2,3 with one bubble each, then wrap to 0.
        do_reset();
        bus.req = 4'b1111;
        repeat (20) step();
        check("rr_writes_in_20", 32'(wr_log.size()), 16);
        for (int g = 0; g < 4; g++) begin
            check($sformatf("rr_grp%0d_first", g), wr_log.size() > 4*g ? 32'(wr_log[4*g]) : 32'hFFFF_FFFF, 32'(g));
            check($sformatf("rr_grp%0d_last", g), wr_log.size() > 4*g+3 ? 32'(wr_log[4*g+3]) : 32'hFFFF_FFFF, 32'(g));
        end
        repeat (2) step();
        check("rr_wrap_to_0", wr_log.size() > 16 ? 32'(wr_log[16]) : 32'hFFFF_FFFF, 0);
`else
        // Producer 0 holds the port beyond the burst limit until it drops its request.
        do_reset();
        bus.req = 4'b1111;
        repeat (13) step();
        check("prio_p0_words", 32'(count_id(0)), 12);
        check("prio_only_p0", 32'(wr_log.size()), 12);
        bus.req = 4'b1110;
        repeat (16) step();
        check("prio_total", 32'(wr_log.size()), 24);
        check("prio_next1", wr_log.size() > 12 ? 32'(wr_log[12]) : 32'hFFFF_FFFF, 1);
        check("prio_next2", wr_log.size() > 16 ? 32'(wr_log[16]) : 32'hFFFF_FFFF, 2);
        check("prio_next3", wr_log.size() > 20 ? 32'(wr_log[20]) : 32'hFFFF_FFFF, 3);
`endif

        // Producer 2 stalled by a full FIFO for 3 cycles after its 2nd word.
        do_reset();
        bus.req = 4'b0100;
        repeat (3) step();
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("full_hold_id", 32'(bus.gnt_id), 2);
            check("full_hold_valid", 32'(bus.gnt_valid), 1);
        end
        bus.fifo_full = 1'b0;
        repeat (3) step();
        check("full_p2_words", 32'(count_id(2)), 4);
        check("full_total_words", 32'(wr_log.size()), 4);
        check("full_grant_over", 32'(bus.gnt_valid), 1);

        // Producer 1 drops after 2 words; next round-robin pick above 1.
        do_reset();
        bus.req = 4'b0010;
        repeat (3) step();
        bus.req = 4'b1001;
        step();
        check("drop_grant_ended", 32'(bus.gnt_valid), 0);
        step();
        check("drop_regrant_valid", 32'(bus.gnt_valid), 1);
        check("drop_next_id", 32'(bus.gnt_id), PRIO ? 32'd0 : 32'd3);
        check("drop_p1_words", 32'(count_id(1)), 2);
        step();

        // Asynchronous reset in the middle of a burst.
        do_reset();
        bus.req = 4'b1111;
        repeat (3) step();
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.gnt_valid), 0);
        check("midrst_ack", 32'(bus.ack), 0);
        check("midrst_wr_en", 32'(bus.fifo_wr_en), 0);
        model_reset();
        seen_ack = '0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        bus.req = 4'b1010;
        step();
        check("midrst_first_id", 32'(bus.gnt_id), 1);
        check("midrst_first_valid", 32'(bus.gnt_valid), 1);
        step();

        // Randomized producers obeying the hold-until-ack rule, with occasional abandons.
        do_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (seen_ack[i]) begin
                    bus.req_data[i*DW +: DW] = 8'($urandom);
                    bus.req[i] = ($urandom_range(0, 3) != 0);
                end else if (!bus.req[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        bus.req[i] = 1'b1;
                        bus.req_data[i*DW +: DW] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 40) == 0) begin
                    bus.req[i] = 1'b0;
                end
            end
            bus.fifo_full = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin write-side arbiter sharing one memory-based FIFO (8-bit, depth 8) among NUM_REQ producers.
- Grants one producer at a time, forwards its words to the FIFO write port, and stalls on FIFO full.
- Limits each grant to BURST_LEN words so every producer gets fair access.
- Sits directly in front of the FIFO; the FIFO read side is untouched.

Parameters:
- DATA_WIDTH, 8: word width; matches FIFO din.
- NUM_REQ, 4: number of producers (2..8).
- ID_W, 2: grant id width; must equal clog2(NUM_REQ).
- BURST_LEN, 4: maximum words per grant (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-producer request; high while producer has a valid word.
- req_data  in  NUM_REQ*DATA_WIDTH  producer words; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ack  out  NUM_REQ  one-hot; word accepted when req[i] and ack[i] are both high on a clock edge.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_din  out  DATA_WIDTH  FIFO write data.
- gnt_valid  out  1  a grant is active.
- gnt_id  out  ID_W  index of the granted producer; valid when gnt_valid=1.

Behaviour:
- Reset (async, rst=1): state=ARB, gnt_valid=0, gnt_id=0, burst_cnt=0, last_gnt=NUM_REQ-1 (producer 0 wins first), ack=0, fifo_wr_en=0, fifo_din=0.
- States: ARB and GRANT.
- ARB:
  - If req is nonzero, select the first requesting index scanning upward from last_gnt+1, modulo NUM_REQ.
  - Register the winner into gnt_id, set gnt_valid=1, clear burst_cnt, go to GRANT.
  - If req=0, stay in ARB.
  - No transfer occurs in ARB: 1-cycle arbitration latency.
- GRANT (combinational outputs from registered grant):
  - xfer = req[gnt_id] & !fifo_full.
  - fifo_wr_en = xfer; ack[gnt_id] = xfer; all other ack bits 0.
  - fifo_din = req_data slice of gnt_id (driven regardless of xfer).
  - On each xfer, burst_cnt increments.
  - Exit to ARB (gnt_valid=0, last_gnt=gnt_id) when either:
    - req[gnt_id]=0 (producer idle), or
    - xfer occurs with burst_cnt==BURST_LEN-1 (burst exhausted).
- fifo_full=1 in GRANT: no transfer, burst_cnt holds, grant holds, no timeout.
- Requests from non-granted producers are ignored until the next ARB cycle.
- Handshake: a producer must hold req and data stable until acked. Dropping req without an ack ends the grant.
- Bubble: exactly 1 idle cycle (ARB) between consecutive grants. Sustained throughput with all producers requesting is BURST_LEN/(BURST_LEN+1).
- Sole requester: re-granted after each bubble, so it keeps full access minus the bubbles.
- burst_cnt width: 4 bits; never exceeds BURST_LEN-1.
- Reset mid-grant: outputs go to reset values immediately; a word in flight that cycle is not written.

Optional Feature:
- Macro: FIFO_WRITE_ARB_PRIO_EN.
- Defined:
  - Producer 0 is high priority. In ARB, if req[0]=1 it wins regardless of last_gnt.
  - Producer 0's grant is not burst-limited; it ends only when req[0] drops.
  - Other producers are arbitrated round-robin as above, but only when req[0]=0.
- Undefined: pure round-robin for all producers, burst limit applies to everyone.

Test Plan:
- Reset then req=4'b0001, data0=8'hA5 held → cycle 1 gnt_valid=1, gnt_id=0; cycle 2 fifo_wr_en=1, fifo_din=8'hA5, ack=4'b0001; 4 words accepted, then 1 ARB bubble, then producer 0 re-granted.
- req=4'b1111 continuously, fifo_full=0 → grant order 0,1,2,3,0; 4 words each; 1 bubble between grants; 16 writes in 20 cycles.
- Producer 2 granted, fifo_full=1 for 3 cycles after its 2nd word → fifo_wr_en=0 and ack=0 for those 3 cycles, gnt_id stays 2; after full drops, words 3-4 are written, then grant ends.
- Producer 1 granted, req[1] drops after 2 words → grant ends with burst_cnt=2; next ARB picks the next requester above 1 (producer 3 if req=4'b1001).
- rst asserted in the middle of a burst → gnt_valid, ack and fifo_wr_en are 0 in the same cycle; after release, with req=4'b1010, producer 1 wins first.
- With FIFO_WRITE_ARB_PRIO_EN defined and req=4'b1111 → producer 0 holds the grant for 10+ words; producers 1, 2, 3 are granted only after req[0] drops.
